// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle RV32I control unit (Moore FSM, ALU decoder, immediate select)
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   op, funct3, funct7_5 instruction fields instr[6:0], instr[14:12], instr[30]
//   zero                ALU zero flag, same cycle
//   pc_write            PC enable (pc_update | branch & zero)
//   adr_src             memory address select (0 PC, 1 result)
//   mem_write           data memory write enable
//   ir_write            instruction / old-PC register enable
//   result_src          result select (00 ALUOut, 01 read data, 10 ALU result)
//   alu_src_a           ALU A select (00 PC, 01 old PC, 10 RD1)
//   alu_src_b           ALU B select (00 RD2, 01 ImmExt, 10 constant 4)
//   reg_write           register file write enable
//   imm_src             immediate format select
//   alu_control         ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   state_o             current state code
module mc_control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t     state, state_next;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = S_FETCH;
        adr_src       = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_update     = 1'b0;
        branch        = 1'b0;
        case (state)
            S_FETCH: begin
                state_next   = S_DECODE;
                ir_write_raw = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                pc_update    = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
            end
            S_MEMREAD: begin
                state_next = S_MEMWB;
                adr_src    = 1'b1;
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                state_next = S_ALUWB;
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
            end
            S_EXECUTEI: begin
                state_next = S_ALUWB;
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                state_next = S_ALUWB;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_update  = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Write enables are gated by reset so nothing architectural changes while
    // rst_n is low; the select outputs keep following the current state.
    assign pc_write  = rst_n & (pc_update | (branch & zero));
    assign ir_write  = rst_n & ir_write_raw;
    assign mem_write = rst_n & mem_write_raw;
    assign reg_write = rst_n & reg_write_raw;
    assign state_o   = state;

    // op[5] separates R-type (sub possible) from I-type (addi never subtracts).
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7_5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 The block SHALL have no parameters; it is fixed to RV32I instruction fields.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 op  input  7  instruction opcode, instr[6:0].
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7_5  input  1  instr[30].
REQ-007 zero  input  1  ALU zero flag from the same cycle.
REQ-008 pc_write  output  1  PC register enable.
REQ-009 adr_src  output  1  memory address select: 0 = PC, 1 = result.
REQ-010 mem_write  output  1  data memory write enable.
REQ-011 ir_write  output  1  instruction/old-PC register enable.
REQ-012 result_src  output  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
REQ-013 alu_src_a  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = RD1.
REQ-014 alu_src_b  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-015 reg_write  output  1  register file write enable.
REQ-016 imm_src  output  2  immediate format select.
REQ-017 alu_control  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-018 state_o  output  4  current state code, for debug and verification.

Function
REQ-019 The FSM SHALL be Moore, with these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10.
REQ-020 The FSM SHALL make these transitions: FETCH->DECODE.
REQ-021 From DECODE, the FSM SHALL go by op: 0000011/0100011->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1100011->BEQ; 1101111->JAL; any other op->FETCH (illegal opcode, no side effects).
REQ-022 From MEMADR, the FSM SHALL go to MEMREAD if op=0000011, else to MEMWRITE.
REQ-023 The FSM SHALL also make these transitions: MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH; EXECUTER/EXECUTEI/JAL->ALUWB->FETCH; BEQ->FETCH; unused state codes 11-15->FETCH.
REQ-024 Any output not listed for a state SHALL be 0.
REQ-025 FETCH outputs SHALL be: adr_src=0, ir_write=1, src_a=00, src_b=10, alu_op=00, result_src=10, pc_update=1.
REQ-026 DECODE outputs SHALL be: src_a=01, src_b=01, alu_op=00.
REQ-027 MEMADR outputs SHALL be: src_a=10, src_b=01, alu_op=00.
REQ-028 MEMREAD outputs SHALL be: result_src=00, adr_src=1.
REQ-029 MEMWB outputs SHALL be: result_src=01, reg_write=1.
REQ-030 MEMWRITE outputs SHALL be: result_src=00, adr_src=1, mem_write=1.
REQ-031 EXECUTER outputs SHALL be: src_a=10, src_b=00, alu_op=10.
REQ-032 EXECUTEI outputs SHALL be: src_a=10, src_b=01, alu_op=10.
REQ-033 ALUWB outputs SHALL be: result_src=00, reg_write=1.
REQ-034 BEQ outputs SHALL be: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1.
REQ-035 JAL outputs SHALL be: src_a=01, src_b=10, alu_op=00, result_src=00, pc_update=1.
REQ-036 pc_write SHALL equal pc_update | (branch & zero), evaluated combinationally, so a BEQ branch is taken only when zero=1 in the BEQ cycle.
REQ-037 The ALU decoder SHALL map alu_op to alu_control: alu_op 00->000 and 01->001; alu_op 10 decodes funct3 as below; alu_op 11->000.
REQ-038 With alu_op 10, funct3 SHALL map: 000->001 if (op[5] & funct7_5), else 000; 010->101; 110->011; 111->010; any other funct3->000.
REQ-039 imm_src SHALL be combinational from op: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, other->00.
REQ-040 Each instruction SHALL take a fixed number of cycles from FETCH: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.

Reset
REQ-041 While rst_n=0 at a rising edge, the next state SHALL be FETCH, including when reset arrives mid-instruction in any state.
REQ-042 While rst_n=0, pc_write, ir_write, mem_write and reg_write SHALL be forced to 0.
REQ-043 All other outputs SHALL follow the current state while rst_n=0.
REQ-044 The first cycle after rst_n rises SHALL be FETCH, with ir_write=1 and pc_write=1.

Verification
REQ-045 lw: op=0000011 -> state_o 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01; mem_write never 1.
REQ-046 sw: op=0100011 -> state_o 0,1,2,5,0; mem_write=1 and adr_src=1 only in state 5; reg_write never 1.
REQ-047 R-type: op=0110011, funct3=000, funct7_5=1 -> alu_control=001 in EXECUTER; the same with funct7_5=0 -> 000; with funct3=010 -> 101; with funct3=111 -> 010.
REQ-048 I-type: op=0010011, funct3=000, funct7_5=1 -> alu_control=000 in EXECUTEI, i.e. addi is never treated as sub.
REQ-049 beq: op=1100011 -> alu_control=001 in BEQ; zero=1 -> pc_write=1, zero=0 -> pc_write=0; the next state is FETCH in both cases.
REQ-050 Illegal op=1111111 -> state_o 0,1,0 with no write enable asserted in DECODE.
REQ-051 Reset: rst_n=0 asserted during MEMREAD -> state_o=0 at the next edge, with all four write enables 0 while rst_n=0.
